// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation and
// FSM state encodings, default widths and the zero-register index.
package muldiv_pkg;

    localparam int DEF_WIDTH          = 64;
    localparam int DEF_REG_ADDR_WIDTH = 5;
    localparam int XZR_INDEX          = 31;

    typedef enum logic [1:0] {
        OP_MUL  = 2'd0,
        OP_UDIV = 2'd1,
        OP_SDIV = 2'd2,
        OP_RSVD = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_div(input op_t op);
        return (op == OP_UDIV) || (op == OP_SDIV);
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Bit-serial arithmetic core. MUL uses shift-add (acc += multiplicand when the
// multiplier LSB is set); UDIV/SDIV use restoring division on magnitudes with
// acc as the partial remainder and shreg shifting dividend bits out while
// quotient bits shift in. result is the value after the current step, with
// the SDIV sign correction applied, so the controller can capture it on the
// final iteration's edge.
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
)
(
    input  logic             clock,
    input  logic             load,
    input  logic             step,
    input  op_t              op,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    output logic [WIDTH-1:0] result
);

    op_t              op_q;
    logic             negate_q;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] opnd;

    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] shreg_next;
    logic [WIDTH-1:0] opnd_next;
    logic [WIDTH:0]   trial;

    // One iteration of shift-add or restoring-divide, plus the finalized result.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        acc_next   = acc;
        shreg_next = shreg;
        opnd_next  = opnd;
        trial      = {acc, shreg[WIDTH-1]} - {1'b0, opnd};
        if (op_q == OP_MUL) begin
            acc_next   = opnd[0] ? acc + shreg : acc;
            shreg_next = shreg << 1;
            opnd_next  = opnd >> 1;
        end else if (!trial[WIDTH]) begin
            acc_next   = trial[WIDTH-1:0];
            shreg_next = {shreg[WIDTH-2:0], 1'b1};
        end else begin
            acc_next   = {acc[WIDTH-2:0], shreg[WIDTH-1]};
            shreg_next = {shreg[WIDTH-2:0], 1'b0};
        end
        if (op_q == OP_MUL)
            result = acc_next;
        else
            result = negate_q ? -shreg_next : shreg_next;
    end

    // Operand capture on accept, then one step per RUN cycle.
    // NOTE: pure data registers carry no reset; the controller never reads
    // them before a load, which keeps reset fan-out off the wide datapath.
    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (load) begin
            op_q <= op;
            acc  <= '0;
            if (op == OP_SDIV) begin
                shreg    <= operandA[WIDTH-1] ? -operandA : operandA;
                opnd     <= operandB[WIDTH-1] ? -operandB : operandB;
                negate_q <= operandA[WIDTH-1] ^ operandB[WIDTH-1];
            end else begin
                shreg    <= operandA;
                opnd     <= operandB;
                negate_q <= 1'b0;
            end
        end else if (step) begin
            acc   <= acc_next;
            shreg <= shreg_next;
            opnd  <= opnd_next;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MUL/UDIV/SDIV execution unit. The IDLE/RUN/DONE controller
// accepts a request, runs WIDTH single-bit iterations in the datapath and
// issues one register-file write. Divide by zero skips RUN and writes 0;
// writes to XZR are suppressed but regWrite/regWriteData still update.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH          = DEF_WIDTH,
    parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH
)
(
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [1:0]                op,
    input  logic [WIDTH-1:0]          operandA,
    input  logic [WIDTH-1:0]          operandB,
    input  logic [REG_ADDR_WIDTH-1:0] destReg,
    output logic                      busy,
    output logic [REG_ADDR_WIDTH-1:0] regWrite,
    output logic [WIDTH-1:0]          regWriteData,
    output logic                      isWrite
);

    localparam int                        COUNT_WIDTH = $clog2(WIDTH);
    localparam logic [REG_ADDR_WIDTH-1:0] XZR         = REG_ADDR_WIDTH'(XZR_INDEX);

    state_t                    state;
    logic [COUNT_WIDTH-1:0]    count;
    logic [REG_ADDR_WIDTH-1:0] dest_q;
    op_t                       op_in;
    logic                      accept;
    logic                      div_by_zero;
    logic                      step_en;
    logic [WIDTH-1:0]          dp_result;

    assign op_in       = op_t'(op);
    assign accept      = !reset && (state == IDLE) && start && (op_in != OP_RSVD);
    assign div_by_zero = is_div(op_in) && (operandB == '0);
    assign step_en     = (state == RUN);

    muldiv_datapath #(
        .WIDTH(WIDTH)
    ) u_datapath (
        .clock   (clock),
        .load    (accept),
        .step    (step_en),
        .op      (op_in),
        .operandA(operandA),
        .operandB(operandB),
        .result  (dp_result)
    );

    // Controller with registered outputs; the write is set up on the edge entering DONE.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            count        <= '0;
            dest_q       <= '0;
            busy         <= 1'b0;
            isWrite      <= 1'b0;
            regWrite     <= '0;
            regWriteData <= '0;
        end else begin
            case (state)
                IDLE: begin
                    isWrite <= 1'b0;
                    if (accept) begin
                        dest_q <= destReg;
                        busy   <= 1'b1;
                        if (div_by_zero) begin
                            state        <= DONE;
                            regWrite     <= destReg;
                            regWriteData <= '0;
                            isWrite      <= (destReg != XZR);
                        end else begin
                            state <= RUN;
                            count <= COUNT_WIDTH'(WIDTH - 1);
                        end
                    end
                end
                RUN: begin
                    count <= count - 1'b1;
                    if (count == '0) begin
                        state        <= DONE;
                        regWrite     <= dest_q;
                        regWriteData <= dp_result;
                        isWrite      <= (dest_q != XZR);
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    isWrite <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    isWrite <= 1'b0;
                end
            endcase
        end
    end

endmodule
